// File: rtl/arinc708_rx_pkg.sv
// ARINC 708 receiver shared types and constants.
// Line states, FSM encodings, frame geometry, flag bit positions.
package arinc708_rx_pkg;

  typedef enum logic [1:0] {
    LN_NULL = 2'd0,
    LN_HI   = 2'd1,
    LN_LO   = 2'd2
  } line_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_SYNC_HI = 3'd2;
  localparam logic [2:0] S_SYNC_LO = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;

  localparam int BITS_PER_FRAME  = 1600;
  localparam int WORDS_PER_FRAME = 50;
  localparam int FIFO_DEPTH      = 512;

  localparam int FLG_NE    = 0;
  localparam int FLG_FRAME = 1;
  localparam int FLG_ERR   = 2;
  localparam int FLG_OVF   = 3;

  function automatic line_t classify(
    input logic a,
    input logic b
  );
    line_t r;
    unique case (1'b1)
      (a && !b): r = LN_HI;
      (!a && b): r = LN_LO;
      default:   r = LN_NULL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arinc708_rx_decoder.sv
// ARINC 708 line decoder: synchronizer, sync detector,
// Manchester bit recovery with mid-bit resync.
module arinc708_rx_decoder
  import arinc708_rx_pkg::*;
#(
  parameter int H = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic InputA,
  input  logic InputB,
  input  logic hold,
  input  logic room,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_last,
  output logic frame_start,
  output logic decode_err,
  output logic overflow,
  output logic active
);

  localparam logic [15:0] QTR      = 16'(H / 2);
  localparam logic [15:0] TQTR     = 16'(3 * H / 2);
  localparam logic [15:0] HALF     = 16'(H);
  localparam logic [15:0] BIT_END  = 16'(2 * H - 1);
  localparam logic [15:0] NULL_END = 16'(2 * H - 1);
  localparam logic [15:0] MIN_RUN  = 16'(5 * H / 2);
  localparam logic [15:0] MAX_RUN  = 16'(7 * H / 2);
  localparam logic [15:0] LO_LEN   = 16'(3 * H);
  localparam logic [10:0] LAST     = 11'(BITS_PER_FRAME - 1);

  logic [1:0]  sa, sb;
  logic [2:0]  state;
  logic [15:0] cnt, timer;
  logic [10:0] bidx;
  line_t       line, prev, h1;

  assign line   = classify(sa[1], sb[1]);
  assign active = (state == S_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      sa   <= '0;
      sb   <= '0;
      prev <= LN_NULL;
    end else begin
      sa   <= {sa[0], InputA};
      sb   <= {sb[0], InputB};
      prev <= line;
    end
  end

  always_ff @(posedge clk) begin
    bit_valid   <= 1'b0;
    bit_last    <= 1'b0;
    frame_start <= 1'b0;
    decode_err  <= 1'b0;
    overflow    <= 1'b0;
    if (reset || hold) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timer     <= '0;
      bidx      <= '0;
      h1        <= LN_NULL;
      bit_value <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (line != LN_NULL) begin
            cnt <= '0;
          end else if (cnt == NULL_END) begin
            state <= S_ARMED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_ARMED: begin
          if (line == LN_HI) begin
            state <= S_SYNC_HI;
            cnt   <= 16'd1;
          end
        end
        S_SYNC_HI: begin
          if (line == LN_HI) begin
            if (cnt >= MAX_RUN) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else if (line == LN_LO && cnt >= MIN_RUN) begin
            state <= S_SYNC_LO;
            cnt   <= 16'd1;
          end else begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        S_SYNC_LO: begin
          if (cnt == LO_LEN) begin
            cnt <= '0;
            if (room) begin
              state       <= S_DATA;
              timer       <= '0;
              bidx        <= '0;
              frame_start <= 1'b1;
            end else begin
              state    <= S_IDLE;
              overflow <= 1'b1;
            end
          end else if (line != LN_LO && cnt < MIN_RUN) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          timer <= (timer == BIT_END) ? '0 : timer + 16'd1;
          // a mid-bit edge re-centres the timer on the half boundary
          if (line != prev && timer > QTR && timer < TQTR)
            timer <= HALF;
          if (timer == QTR)
            h1 <= line;
          if (timer == TQTR) begin
            if (h1 == line || h1 == LN_NULL || line == LN_NULL) begin
              decode_err <= 1'b1;
              state      <= S_IDLE;
              cnt        <= '0;
            end else begin
              bit_valid <= 1'b1;
              bit_value <= (h1 == LN_HI);
              bidx      <= bidx + 11'd1;
              if (bidx == LAST) begin
                bit_last <= 1'b1;
                state    <= S_IDLE;
                cnt      <= '0;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arinc708_rx_controller.sv
// ARINC 708 receive controller: word packing, frame-commit
// FIFO with pending/committed pointers, sticky flags, IRQ.
module arinc708_rx_controller
  import arinc708_rx_pkg::*;
#(
  parameter int INPUTFREQUENCY = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InputA,
  input  logic        InputB,
  input  logic [3:0]  rxconfig,
  input  logic [3:0]  rxintmask,
  output logic [26:0] rxintflag,
  output logic        IRQ,
  input  logic        IRQ_clear,
  output logic [31:0] bufer_data,
  input  logic        bufer_rd,
  output logic        rx_empty
);

  localparam int H = INPUTFREQUENCY / 2_000_000;

  logic        en, flush;
  logic        bit_valid, bit_value, bit_last;
  logic        frame_start, decode_err, overflow, active;
  logic [31:0] mem [FIFO_DEPTH];
  logic [8:0]  rp, wp, wc;
  logic [9:0]  count;
  logic [5:0]  npend;
  logic [4:0]  bcnt;
  logic [30:0] sr;
  logic [10:0] free;
  logic        room, pop, wr, commit;
  logic        f_frame, f_err, f_ovf;
  logic [3:0]  flags;
  logic        unused_cfg;

  assign en         = rxconfig[0];
  assign flush      = rxconfig[1];
  assign unused_cfg = ^rxconfig[3:2];

  assign free = 11'd512 - {1'b0, count} - {5'd0, npend};
  assign room = free >= 11'(WORDS_PER_FRAME);
  assign pop  = bufer_rd && (count != 10'd0);
  assign wr   = bit_valid && (bcnt == 5'd31) && en && !flush;
  assign commit = wr && bit_last;

  arinc708_rx_decoder #(.H(H)) u_dec (
    .clk         (clk),
    .reset       (reset),
    .InputA      (InputA),
    .InputB      (InputB),
    .hold        (!en || flush),
    .room        (room),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .bit_last    (bit_last),
    .frame_start (frame_start),
    .decode_err  (decode_err),
    .overflow    (overflow),
    .active      (active)
  );

  always_ff @(posedge clk) begin
    if (wr)
      mem[wp] <= {sr, bit_value};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rp    <= '0;
      wp    <= '0;
      wc    <= '0;
      count <= '0;
      npend <= '0;
      bcnt  <= '0;
      sr    <= '0;
    end else begin
      if (bit_valid) begin
        sr   <= {sr[29:0], bit_value};
        bcnt <= bcnt + 5'd1;
      end
      if (frame_start)
        bcnt <= '0;
      if (wr) begin
        wp    <= wp + 9'd1;
        npend <= npend + 6'd1;
      end
      // a partial frame is discarded by rewinding to the last commit
      if (!en || decode_err) begin
        wp    <= wc;
        npend <= '0;
      end else if (commit) begin
        wc    <= wp + 9'd1;
        npend <= '0;
      end
      if (pop)
        rp <= rp + 9'd1;
      count <= count - {9'd0, pop}
             + (commit ? 10'(WORDS_PER_FRAME) : 10'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_frame <= 1'b0;
      f_err   <= 1'b0;
      f_ovf   <= 1'b0;
    end else begin
      if (IRQ_clear) begin
        f_frame <= 1'b0;
        f_err   <= 1'b0;
        f_ovf   <= 1'b0;
      end
      if (commit)
        f_frame <= 1'b1;
      if (decode_err && en && !flush)
        f_err <= 1'b1;
      if (overflow && en && !flush)
        f_ovf <= 1'b1;
    end
  end

  assign rx_empty   = (count == 10'd0);
  assign bufer_data = rx_empty ? 32'd0 : mem[rp];

  always_comb begin
    flags            = '0;
    flags[FLG_NE]    = !rx_empty;
    flags[FLG_FRAME] = f_frame;
    flags[FLG_ERR]   = f_err;
    flags[FLG_OVF]   = f_ovf;
  end

  assign rxintflag = {active, count, 12'd0, flags};
  assign IRQ       = |(flags & rxintmask);

endmodule

// File: tb/tb_arinc708_rx_controller.sv
// Self-checking bench for arinc708_rx_controller.
// Random payloads checked against a queue-based FIFO model.
module tb_arinc708_rx_controller;

  localparam int FREQ = 16_000_000;
  localparam int H    = FREQ / 2_000_000;

  logic        clk = 1'b0;
  logic        reset;
  logic        InputA, InputB;
  logic [3:0]  rxconfig, rxintmask;
  logic [26:0] rxintflag;
  logic        IRQ, IRQ_clear;
  logic [31:0] bufer_data;
  logic        bufer_rd, rx_empty;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] payload [50];
  logic [31:0] model_q [$];
  logic        m_frame, m_err, m_ovf;

  always #5 clk = ~clk;

  arinc708_rx_controller #(.INPUTFREQUENCY(FREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .InputA     (InputA),
    .InputB     (InputB),
    .rxconfig   (rxconfig),
    .rxintmask  (rxintmask),
    .rxintflag  (rxintflag),
    .IRQ        (IRQ),
    .IRQ_clear  (IRQ_clear),
    .bufer_data (bufer_data),
    .bufer_rd   (bufer_rd),
    .rx_empty   (rx_empty)
  );

  task automatic drive(input int lvl, input int n);
    InputA = (lvl == 1);
    InputB = (lvl == 2);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(
    input bit jit,
    input int bad_bit,
    input int stop_at,
    input bit cut_en
  );
    int          h1, h2;
    logic [31:0] w;
    logic        bv;
    drive(0, 40);
    drive(1, 3 * H);
    drive(2, 3 * H);
    for (int b = 0; b < 1600; b++) begin
      if (b == stop_at) begin
        if (cut_en) rxconfig[0] = 1'b0;
        break;
      end
      w  = payload[b / 32];
      bv = w[31 - (b % 32)];
      h1 = jit ? ($urandom_range(1) != 0 ? H - 1 : H + 1) : H;
      h2 = jit ? ($urandom_range(1) != 0 ? H - 1 : H + 1) : H;
      if (b == bad_bit) begin
        drive(1, h1); drive(1, h2);
      end else if (bv) begin
        drive(1, h1); drive(2, h2);
      end else begin
        drive(2, h1); drive(1, h2);
      end
    end
    drive(0, 10);
  endtask

  task automatic rand_payload();
    for (int k = 0; k < 50; k++) payload[k] = $urandom;
  endtask

  task automatic accept_frame();
    for (int k = 0; k < 50; k++) model_q.push_back(payload[k]);
    m_frame = 1'b1;
  endtask

  task automatic clear_flags();
    IRQ_clear = 1'b1;
    @(negedge clk);
    IRQ_clear = 1'b0;
    m_frame = 0; m_err = 0; m_ovf = 0;
  endtask

  function automatic logic [3:0] exp_flags();
    return {m_ovf, m_err, m_frame, model_q.size() != 0};
  endfunction

  task automatic test_reset();
    reset = 1'b1; rxconfig = 4'd0; rxintmask = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (rx_empty !== 1'b1) begin
      fails++; $display("FAIL reset_empty got %b want 1", rx_empty);
    end
    tests++;
    if (rxintflag !== 27'd0) begin
      fails++; $display("FAIL reset_flag got %h want 0", rxintflag);
    end
    tests++;
    if (IRQ !== 1'b0) begin
      fails++; $display("FAIL reset_irq got %b want 0", IRQ);
    end
    tests++;
    if (bufer_data !== 32'd0) begin
      fails++; $display("FAIL reset_data got %h want 0", bufer_data);
    end
    rxconfig = 4'b0001;
  endtask

  task automatic test_decode_error();
    rand_payload();
    rxintmask = 4'b0100;
    send_frame(1'b0, 800, 801, 1'b0);
    m_err = 1'b1;
    tests++;
    if (rxintflag[3:0] !== exp_flags()) begin
      fails++;
      $display("FAIL err_flags got %b want %b", rxintflag[3:0], exp_flags());
    end
    tests++;
    if (rxintflag[25:16] !== 10'd0 || rx_empty !== 1'b1) begin
      fails++;
      $display("FAIL err_count got %0d/%b want 0/1", rxintflag[25:16], rx_empty);
    end
    tests++;
    if (IRQ !== 1'b1) begin
      fails++; $display("FAIL err_irq got %b want 1", IRQ);
    end
  endtask

  task automatic test_good_frame();
    for (int k = 0; k < 50; k++) payload[k] = 32'hA5A5_0000 + k;
    clear_flags();
    rxintmask = 4'b0010;
    fork
      send_frame(1'b0, -1, -1, 1'b0);
      begin
        repeat (40 + 6 * H + 1000 * 2 * H) @(negedge clk);
        tests++;
        if (rx_empty !== 1'b1 || rxintflag[26] !== 1'b1) begin
          fails++;
          $display("FAIL midframe got empty=%b busy=%b want 1/1", rx_empty, rxintflag[26]);
        end
      end
    join
    accept_frame();
    tests++;
    if (rxintflag[3:0] !== exp_flags()) begin
      fails++;
      $display("FAIL good_flags got %b want %b", rxintflag[3:0], exp_flags());
    end
    tests++;
    if (rxintflag[25:16] !== 10'(model_q.size())) begin
      fails++;
      $display("FAIL good_count got %0d want %0d", rxintflag[25:16], model_q.size());
    end
    tests++;
    if (IRQ !== 1'b1) begin
      fails++; $display("FAIL good_irq got %b want 1", IRQ);
    end
    tests++;
    if (bufer_data !== model_q[0]) begin
      fails++; $display("FAIL good_head got %h want %h", bufer_data, model_q[0]);
    end
  endtask

  task automatic test_jitter();
    rand_payload();
    send_frame(1'b1, -1, -1, 1'b0);
    accept_frame();
    tests++;
    if (rxintflag[25:16] !== 10'(model_q.size())) begin
      fails++;
      $display("FAIL jit_count got %0d want %0d", rxintflag[25:16], model_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [9:0] prev;
    bit         seen;
    logic [31:0] exp;
    rxintmask = 4'b1000;
    for (int f = 0; f < 8; f++) begin
      rand_payload();
      if (f == 2) begin
        seen = 0;
        prev = rxintflag[25:16];
        fork
          send_frame(1'b0, -1, -1, 1'b0);
          begin
            IRQ_clear = 1'b1;
            for (int c = 0; c < 30000 && !seen; c++) begin
              @(negedge clk);
              if (rxintflag[25:16] !== prev) seen = 1;
            end
            IRQ_clear = 1'b0;
          end
        join
        m_frame = 0; m_err = 0; m_ovf = 0;
        accept_frame();
        tests++;
        if (!seen) begin
          fails++; $display("FAIL collide_timeout got none want commit");
        end
        tests++;
        if (rxintflag[3:0] !== exp_flags()) begin
          fails++;
          $display("FAIL collide_flags got %b want %b", rxintflag[3:0], exp_flags());
        end
        clear_flags();
        tests++;
        if (rxintflag[3:1] !== 3'b000) begin
          fails++; $display("FAIL clear_flags got %b want 000", rxintflag[3:1]);
        end
      end else begin
        send_frame(1'b0, -1, -1, 1'b0);
        accept_frame();
      end
    end
    tests++;
    if (rxintflag[25:16] !== 10'd500) begin
      fails++; $display("FAIL preload_count got %0d want 500", rxintflag[25:16]);
    end
    rand_payload();
    send_frame(1'b0, -1, 40, 1'b0);
    if (512 - model_q.size() < 50) m_ovf = 1'b1;
    tests++;
    if (rxintflag[3:0] !== exp_flags() || IRQ !== m_ovf) begin
      fails++;
      $display("FAIL ovf_flags got %b/%b want %b", rxintflag[3:0], IRQ, exp_flags());
    end
    tests++;
    if (rxintflag[25:16] !== 10'(model_q.size())) begin
      fails++;
      $display("FAIL ovf_count got %0d want %0d", rxintflag[25:16], model_q.size());
    end
    for (int i = 0; i < 50; i++) begin
      bufer_rd = 1'b1;
      exp = model_q.pop_front();
      tests++;
      if (bufer_data !== exp) begin
        fails++; $display("FAIL drain1[%0d] got %h want %h", i, bufer_data, exp);
      end
      @(negedge clk);
    end
    bufer_rd = 1'b0;
    rand_payload();
    send_frame(1'b0, -1, -1, 1'b0);
    accept_frame();
    tests++;
    if (rxintflag[25:16] !== 10'(model_q.size()) || rxintflag[1] !== 1'b1) begin
      fails++;
      $display("FAIL accept_count got %0d want %0d", rxintflag[25:16], model_q.size());
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      bufer_rd = 1'b1;
      exp = model_q.pop_front();
      tests++;
      if (bufer_data !== exp) begin
        fails++; $display("FAIL drain2[%0d] got %h want %h", i, bufer_data, exp);
      end
      @(negedge clk);
    end
    bufer_rd = 1'b0;
    tests++;
    if (rxintflag[25:16] !== 10'd100) begin
      fails++; $display("FAIL held_count got %0d want 100", rxintflag[25:16]);
    end
    rxconfig = 4'b0011;
    @(negedge clk);
    rxconfig = 4'b0001;
    model_q.delete();
    tests++;
    if (rxintflag[25:16] !== 10'd0 || rx_empty !== 1'b1) begin
      fails++;
      $display("FAIL flush got %0d/%b want 0/1", rxintflag[25:16], rx_empty);
    end
  endtask

  task automatic test_enable_drop();
    clear_flags();
    rand_payload();
    send_frame(1'b0, -1, 400, 1'b1);
    rxconfig = 4'b0001;
    tests++;
    if (rxintflag[3:0] !== exp_flags() || rxintflag[26] !== 1'b0) begin
      fails++;
      $display("FAIL endrop_flags got %b want %b", rxintflag[3:0], exp_flags());
    end
    tests++;
    if (rxintflag[25:16] !== 10'(model_q.size()) || rx_empty !== 1'b1) begin
      fails++;
      $display("FAIL endrop_count got %0d want %0d", rxintflag[25:16], model_q.size());
    end
  endtask

  initial begin
    InputA = 0; InputB = 0; IRQ_clear = 0; bufer_rd = 0;
    m_frame = 0; m_err = 0; m_ovf = 0;
    test_reset();
    test_decode_error();
    test_good_frame();
    test_jitter();
    test_overflow();
    test_flush();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
